seg7_scan_capture: RTL and testbench



---
 rtl/seg7_scan_capture.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Receive-side capture for a 4-digit multiplexed 7-segment scan: rebuilds the
// per-digit cathode bytes from the anode strobes and flags frames, bad anodes and stalls.
module seg7_scan_capture #(
    parameter int SETTLE    = 16,
    parameter int TIMEOUT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anodo_in,
    input  logic [7:0] catodo_in,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [3:0] digit_seen,
    output logic       frame_valid,
    output logic       scan_error,
    output logic       stalled
);

    localparam int DW = $clog2(SETTLE) + 1;
    localparam logic [DW-1:0]        SETTLE_C  = DW'(SETTLE);
    localparam logic [DW-1:0]        SETTLE_M1 = DW'(SETTLE - 1);
    localparam logic [TIMEOUT_W-1:0] WD_MAX    = {TIMEOUT_W{1'b1}};

    logic [3:0]           a_meta_q, a_sync_q, a_prev_q;
    logic [7:0]           c_meta_q, c_sync_q;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic                 captured_q, captured_d;
    logic [3:0][7:0]      out_q, out_d;
    logic [3:0]           seen_q, seen_d;
    logic                 fv_q, fv_d;
    logic                 err_q, err_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 stalled_q, stalled_d;

    logic       a_valid_s;
    logic [1:0] a_idx_s;
    logic       a_chg_s;
    logic       a_illegal_s;
    logic       capture_s;
    logic [3:0] nxt_s;

    // Returns {valid, index} for a one-hot active-low anode pattern.
    function automatic logic [2:0] decode_anode(input logic [3:0] a);
        logic [2:0] r;
        case (a)
            4'b1110: r = {1'b1, 2'd0};
            4'b1101: r = {1'b1, 2'd1};
            4'b1011: r = {1'b1, 2'd2};
            4'b0111: r = {1'b1, 2'd3};
            default: r = {1'b0, 2'd0};
        endcase
        return r;
    endfunction

    // Next-state logic: dwell timing, capture, frame tracking, watchdog.
    always_comb begin
        dwell_d    = dwell_q;
        captured_d = captured_q;
        out_d      = out_q;
        seen_d     = seen_q;
        fv_d       = 1'b0;
        err_d      = err_q;
        wd_d       = wd_q;
        stalled_d  = stalled_q;

        {a_valid_s, a_idx_s} = decode_anode(a_sync_q);
        a_chg_s     = (a_sync_q != a_prev_q);
        a_illegal_s = !a_valid_s && (a_sync_q != 4'b1111);
        // The change guard keeps a stale count from the previous digit from firing a capture.
        capture_s   = a_valid_s && !a_chg_s && !captured_q && (dwell_q == SETTLE_M1);
        nxt_s       = seen_q | (4'b0001 << a_idx_s);

        if (a_chg_s || !a_valid_s) begin
            dwell_d = {DW{1'b0}};
        end else if (dwell_q != SETTLE_C) begin
            dwell_d = dwell_q + DW'(1);
        end else begin
            dwell_d = dwell_q;
        end

        if (a_chg_s) begin
            captured_d = 1'b0;
        end else if (capture_s) begin
            captured_d = 1'b1;
        end else begin
            captured_d = captured_q;
        end

        if (capture_s) begin
            out_d[a_idx_s] = c_sync_q;
            if (nxt_s == 4'b1111) begin
                fv_d   = 1'b1;
                seen_d = 4'b0000;
            end else begin
                seen_d = nxt_s;
            end
            wd_d = {TIMEOUT_W{1'b0}};
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + TIMEOUT_W'(1);
        end else begin
            wd_d = wd_q;
        end

        err_d     = err_q | a_illegal_s;
        stalled_d = (wd_d == WD_MAX);
    end

    // State registers, including the two-flop input synchronizers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_meta_q   <= 4'b1111;
            a_sync_q   <= 4'b1111;
            a_prev_q   <= 4'b1111;
            c_meta_q   <= 8'hFF;
            c_sync_q   <= 8'hFF;
            dwell_q    <= {DW{1'b0}};
            captured_q <= 1'b0;
            out_q      <= {4{8'hFF}};
            seen_q     <= 4'b0000;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= {TIMEOUT_W{1'b0}};
            stalled_q  <= 1'b0;
        end else begin
            a_meta_q   <= anodo_in;
            a_sync_q   <= a_meta_q;
            a_prev_q   <= a_sync_q;
            c_meta_q   <= catodo_in;
            c_sync_q   <= c_meta_q;
            dwell_q    <= dwell_d;
            captured_q <= captured_d;
            out_q      <= out_d;
            seen_q     <= seen_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            stalled_q  <= stalled_d;
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign digit_seen  = seen_q;
    assign frame_valid = fv_q;
    assign scan_error  = err_q;
    assign stalled     = stalled_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: table-driven scenarios, hand-written corner sequences
// and a randomized scan, all checked every cycle against a run-length reference model.
module tb_seg7_scan_capture;

    localparam int SETTLE = 4;
    localparam int WD_MAX = 63;

    logic       clk;
    logic       rst;
    logic [3:0] anodo_in;
    logic [7:0] catodo_in;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] digit_seen;
    logic       frame_valid, scan_error, stalled;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int fv_cnt   = 0;

    seg7_scan_capture #(.SETTLE(SETTLE), .TIMEOUT_W(6)) dut (
        .clk(clk), .rst(rst), .anodo_in(anodo_in), .catodo_in(catodo_in),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .digit_seen(digit_seen), .frame_valid(frame_valid),
        .scan_error(scan_error), .stalled(stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pins reach the logic two clocks late; a digit is captured
    // when its anode has been seen valid for SETTLE+1 consecutive cycles.
    logic [3:0] m_a_pipe [2];
    logic [7:0] m_c_pipe [2];
    logic [3:0] m_a_last;
    int         m_run;
    logic [7:0] m_out [4];
    logic [3:0] m_seen;
    logic       m_fv, m_err;
    int         m_wd;

    function automatic int lows(input logic [3:0] a);
        int n = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_a_pipe[0] = 4'hF; m_a_pipe[1] = 4'hF; m_a_last = 4'hF;
        m_c_pipe[0] = 8'hFF; m_c_pipe[1] = 8'hFF;
        m_run = 0;
        for (int k = 0; k < 4; k++) m_out[k] = 8'hFF;
        m_seen = 4'h0; m_fv = 1'b0; m_err = 1'b0; m_wd = 0;
    endtask

    task automatic model_edge();
        logic [3:0] a;
        logic [7:0] c;
        bit v;
        int idx;
        a = m_a_pipe[1];
        c = m_c_pipe[1];
        v = (lows(a) == 1);
        idx = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) idx = k;
        if (v && a == m_a_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = v ? 1 : 0;
        m_fv = 1'b0;
        if (v && m_run == SETTLE + 1) begin
            m_out[idx] = c;
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                m_fv = 1'b1;
                m_seen = 4'h0;
            end
            m_wd = 0;
        end else if (m_wd < WD_MAX) begin
            m_wd++;
        end
        if (lows(a) >= 2) m_err = 1'b1;
        m_a_last = a;
        m_a_pipe[1] = m_a_pipe[0]; m_a_pipe[0] = anodo_in;
        m_c_pipe[1] = m_c_pipe[0]; m_c_pipe[0] = catodo_in;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare at next negedge.
    task automatic step(input logic r, input logic [3:0] an, input logic [7:0] ca);
        rst = r; anodo_in = an; catodo_in = ca;
        if (r) model_reset();
        @(posedge clk);
        if (!r) model_edge();
        @(negedge clk);
        if (frame_valid) fv_cnt++;
        check("cycle", {25'd0, out3, out2, out1, out0, digit_seen, frame_valid, scan_error, stalled},
              {25'd0, m_out[3], m_out[2], m_out[1], m_out[0], m_seen, m_fv, m_err, (m_wd == WD_MAX)});
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  an;
        logic [7:0]  ca;
        int          n;
        logic [31:0] e_out;
        logic [3:0]  e_seen;
        logic        e_err;
    } row_t;

    row_t tbl [22];
    int   fv_snap;
    int   cnt;
    logic prev_stall;

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 8'hFF, 2,  32'hFFFFFFFF, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 4'hE, 8'hC0, 10, 32'hFFFFFFC0, 4'h1, 1'b0};
        tbl[2]  = '{1'b0, 4'hD, 8'hF9, 10, 32'hFFFFF9C0, 4'h3, 1'b0};
        tbl[3]  = '{1'b0, 4'hB, 8'hA4, 10, 32'hFFA4F9C0, 4'h7, 1'b0};
        tbl[4]  = '{1'b0, 4'h7, 8'hB0, 10, 32'hB0A4F9C0, 4'h0, 1'b0};
        tbl[5]  = '{1'b1, 4'hF, 8'hFF, 2,  32'hFFFFFFFF, 4'h0, 1'b0};
        tbl[6]  = '{1'b0, 4'hD, 8'h12, 3,  32'hFFFFFFFF, 4'h0, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 8'h12, 10, 32'hFFFFFFFF, 4'h0, 1'b0};
        tbl[8]  = '{1'b0, 4'hE, 8'h3F, 5,  32'hFFFFFFFF, 4'h0, 1'b0};
        tbl[9]  = '{1'b0, 4'hE, 8'h00, 10, 32'hFFFFFF3F, 4'h1, 1'b0};
        tbl[10] = '{1'b0, 4'hC, 8'h55, 5,  32'hFFFFFF3F, 4'h1, 1'b1};
        tbl[11] = '{1'b0, 4'hD, 8'hF9, 10, 32'hFFFFF93F, 4'h3, 1'b1};
        tbl[12] = '{1'b0, 4'hB, 8'hA4, 10, 32'hFFA4F93F, 4'h7, 1'b1};
        tbl[13] = '{1'b0, 4'h7, 8'hB0, 10, 32'hB0A4F93F, 4'h0, 1'b1};
        tbl[14] = '{1'b1, 4'hF, 8'hFF, 2,  32'hFFFFFFFF, 4'h0, 1'b0};
        tbl[15] = '{1'b0, 4'hE, 8'hC0, 10, 32'hFFFFFFC0, 4'h1, 1'b0};
        tbl[16] = '{1'b0, 4'hD, 8'hF9, 10, 32'hFFFFF9C0, 4'h3, 1'b0};
        tbl[17] = '{1'b1, 4'hF, 8'hFF, 2,  32'hFFFFFFFF, 4'h0, 1'b0};
        tbl[18] = '{1'b0, 4'hE, 8'h11, 10, 32'hFFFFFF11, 4'h1, 1'b0};
        tbl[19] = '{1'b0, 4'hD, 8'h22, 10, 32'hFFFF2211, 4'h3, 1'b0};
        tbl[20] = '{1'b0, 4'hB, 8'h33, 10, 32'hFF332211, 4'h7, 1'b0};
        tbl[21] = '{1'b0, 4'h7, 8'h44, 10, 32'h44332211, 4'h0, 1'b0};

        rst = 1'b1; anodo_in = 4'hF; catodo_in = 8'hFF;
        model_reset();
        @(negedge clk);

        fv_snap = 0;
        for (int i = 0; i < 22; i++) begin
            if (i == 1 || i == 18) fv_snap = fv_cnt;
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].an, tbl[i].ca);
            check($sformatf("row%0d", i), {27'd0, out3, out2, out1, out0, digit_seen, scan_error},
                  {27'd0, tbl[i].e_out, tbl[i].e_seen, tbl[i].e_err});
            if (i == 4 || i == 21)
                check($sformatf("frames_row%0d", i), 64'(fv_cnt - fv_snap), 64'd1);
        end

        // Latency: the pin edge is sampled at the first clock, capture shows 6 clocks later.
        step(1'b1, 4'hF, 8'hFF);
        step(1'b1, 4'hF, 8'hFF);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 4'hE, 8'hC0);
            if (k == 6) check("lat_before", 64'(out0), 64'hFF);
            if (k == 7) check("lat_capture", 64'(out0), 64'hC0);
        end

        // Stall: no further capture while the same anode stays on.
        cnt = 0;
        while (!stalled && cnt < 100) begin
            step(1'b0, 4'hE, 8'hC0);
            cnt++;
        end
        check("stall_cycles", 64'(cnt), 64'd63);
        cnt = 0;
        prev_stall = stalled;
        while (out1 == 8'hFF && cnt < 20) begin
            prev_stall = stalled;
            step(1'b0, 4'hD, 8'h5A);
            cnt++;
        end
        check("stall_clear", {62'd0, prev_stall, stalled}, {62'd0, 1'b1, 1'b0});
        check("stall_capture", 64'(out1), 64'h5A);

        // Randomized scan with occasional blanking and rare illegal patterns.
        for (int d = 0; d < 300; d++) begin
            logic [3:0] an;
            int sel;
            int hold;
            sel = int'($urandom_range(0, 40));
            case (sel % 5)
                0: an = 4'hE;
                1: an = 4'hD;
                2: an = 4'hB;
                3: an = 4'h7;
                default: an = 4'hF;
            endcase
            if (sel == 40) an = 4'h5;
            hold = int'($urandom_range(1, 8));
            for (int k = 0; k < hold; k++) step(1'b0, an, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
